// File: rtl/mem_arbiter.sv
// Two-client arbiter sharing a pipelined fixed-latency memory between icache and dcache miss ports.
// Define ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests (default: icache priority).
module mem_arbiter #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int MEM_LAT = 4,
    parameter int CNT_W   = 3
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_ren,
    input  logic              i_wen,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_data_valid,
    output logic              i_stall,

    input  logic              d_ren,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_data_valid,
    output logic              d_stall,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ren,
    output logic              mem_wen,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_data_valid
);

    typedef enum logic [1:0] {
        IDLE,
        GNT_I,
        GNT_D,
        DRAIN
    } state_t;

    // A full read pipeline never holds more than MEM_LAT reads after the update.
    localparam logic [CNT_W-1:0] OUTST_MAX = CNT_W'(MEM_LAT);

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] outst_q, outst_d;

    logic i_req;
    logic d_req;
    logic pick_dc;
    logic rd_retire;

    assign i_req = i_ren | i_wen;
    assign d_req = d_ren | d_wen;

`ifdef ARB_ROUND_ROBIN_EN
    assign pick_dc = (i_req && d_req) ? ~last_q : ~i_req;
`else
    assign pick_dc = ~i_req;
`endif

    // Returns with nothing outstanding are dropped rather than underflowing.
    assign rd_retire = mem_data_valid && (outst_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            outst_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            outst_q <= outst_d;
            assert (!(mem_data_valid && (outst_q == '0)));
            assert (outst_q <= OUTST_MAX);
            assert (!((state_q == GNT_I) || (state_q == GNT_D)) || (last_q == owner_q));
        end
    end

    always_comb begin
        outst_d = outst_q;
        if (mem_ren && !rd_retire) begin
            outst_d = outst_q + CNT_W'(1);
        end else if (!mem_ren && rd_retire) begin
            outst_d = outst_q - CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    state_d = pick_dc ? GNT_D : GNT_I;
                    owner_d = pick_dc;
                    last_d  = pick_dc;
                end
            end
            GNT_I: begin
                if (!i_req) begin
                    state_d = (outst_d != '0) ? DRAIN : IDLE;
                end
            end
            GNT_D: begin
                if (!d_req) begin
                    state_d = (outst_d != '0) ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (outst_d == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        case (state_q)
            GNT_I: begin
                mem_addr  = i_addr;
                mem_wdata = i_wdata;
                mem_ren   = i_ren;
                mem_wen   = i_wen;
            end
            GNT_D: begin
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                mem_ren   = d_ren;
                mem_wen   = d_wen;
            end
            default: ;
        endcase

        // Held to zero while reset is asserted, even with a client still requesting.
        i_stall      = !rst && i_req && (state_q != GNT_I);
        d_stall      = !rst && d_req && (state_q != GNT_D);
        i_rdata      = (!rst && !owner_q) ? mem_rdata : '0;
        d_rdata      = (!rst &&  owner_q) ? mem_rdata : '0;
        i_data_valid = !rst && !owner_q && rd_retire;
        d_data_valid = !rst &&  owner_q && rd_retire;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random cache-like bursts against a queue-based model.
// Honours ARB_ROUND_ROBIN_EN the same way as the design.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 16;
    localparam int MEM_LAT = 4;
    localparam int CNT_W   = 3;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic i_ren, i_wen, i_data_valid, i_stall;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_wdata, i_rdata;
    logic d_ren, d_wen, d_data_valid, d_stall;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata, d_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic mem_ren, mem_wen, mem_data_valid;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .i_ren(i_ren), .i_wen(i_wen), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_data_valid(i_data_valid), .i_stall(i_stall),
        .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_data_valid(d_data_valid), .d_stall(d_stall),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid)
    );

    // Memory: fixed-latency read pipeline returning address-derived data, cleared by the shared reset.
    function automatic logic [DATA_W-1:0] memf(input logic [ADDR_W-1:0] a);
        return a ^ 16'h5A3C;
    endfunction

    logic [MEM_LAT-1:0] pv;
    logic [ADDR_W-1:0]  pa [MEM_LAT];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pv <= '0;
        end else begin
            pv    <= {pv[MEM_LAT-2:0], mem_ren};
            pa[0] <= mem_addr;
            for (int k = 1; k < MEM_LAT; k++) pa[k] <= pa[k-1];
        end
    end
    assign mem_data_valid = pv[MEM_LAT-1];
    assign mem_rdata      = pv[MEM_LAT-1] ? memf(pa[MEM_LAT-1]) : '0;

    // Reference model: who holds the memory, and the ordered list of reads still in flight.
    typedef enum {FREE, OWN_I, OWN_D, FLUSH} phase_t;
    typedef struct {
        int                tag;
        logic [ADDR_W-1:0] addr;
    } rd_t;

    phase_t ph;
    int     m_owner, m_last;
    rd_t    inflight[$];
    int     gseq[$];
    logic   prev_ren;

    int vectors, miscompares;
    int cnt_iv, cnt_dv, cnt_wr;

    // Client behaviour: bursts of requests, held steady until each beat is accepted.
    int                c_rem[2], c_idle[2];
    bit                c_wr[2], c_auto[2];
    logic [ADDR_W-1:0] c_addr[2];
    logic [DATA_W-1:0] c_wd[2];
    int                fix_len, fix_idle;
    bit                allow_wr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_clients();
        for (int c = 0; c < 2; c++) begin
            if (c_rem[c] == 0 && c_auto[c]) begin
                if (c_idle[c] > 0) begin
                    c_idle[c]--;
                end else begin
                    c_rem[c]  = (fix_len > 0) ? fix_len : int'($urandom_range(1, 8));
                    c_wr[c]   = allow_wr && (c == 1) && ($urandom_range(0, 3) == 0);
                    if (c_wr[c]) c_rem[c] = 1;
                    c_addr[c] = 16'($urandom) & 16'hFFFE;
                    c_wd[c]   = 16'($urandom);
                end
            end
        end
        i_ren   = (c_rem[0] > 0) && !c_wr[0];
        i_wen   = (c_rem[0] > 0) &&  c_wr[0];
        i_addr  = (c_rem[0] > 0) ? c_addr[0] : 16'($urandom);
        i_wdata = (c_rem[0] > 0) ? c_wd[0]   : 16'($urandom);
        d_ren   = (c_rem[1] > 0) && !c_wr[1];
        d_wen   = (c_rem[1] > 0) &&  c_wr[1];
        d_addr  = (c_rem[1] > 0) ? c_addr[1] : 16'($urandom);
        d_wdata = (c_rem[1] > 0) ? c_wd[1]   : 16'($urandom);
    endtask

    task automatic accept(input int c);
        c_rem[c]--;
        c_addr[c] = c_addr[c] + 16'd2;
        if (c_rem[c] == 0) c_idle[c] = (fix_idle > 0) ? fix_idle : int'($urandom_range(1, 4));
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle();
        logic ir, dr, e_ren, e_wen, e_iv, e_dv, i_acc, d_acc;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wd;
        int g, w;
        phase_t nm;
        rd_t r;
        #1;
        ir = i_ren | i_wen;
        dr = d_ren | d_wen;
        if (rst) begin
            chk("rst_mem_ren", mem_ren, 0);
            chk("rst_mem_wen", mem_wen, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_i_stall", i_stall, 0);
            chk("rst_d_stall", d_stall, 0);
            chk("rst_i_valid", i_data_valid, 0);
            chk("rst_d_valid", d_data_valid, 0);
            chk("rst_i_rdata", i_rdata, 0);
            chk("rst_d_rdata", d_rdata, 0);
            prev_ren = 1'b0;
            @(posedge clk);
            ph = FREE;
            m_owner = 0;
            m_last = 1;
            inflight.delete();
            @(negedge clk);
            return;
        end
        g      = (ph == OWN_I) ? 0 : (ph == OWN_D) ? 1 : -1;
        e_ren  = (g == 0) ? i_ren   : (g == 1) ? d_ren   : 1'b0;
        e_wen  = (g == 0) ? i_wen   : (g == 1) ? d_wen   : 1'b0;
        e_addr = (g == 0) ? i_addr  : (g == 1) ? d_addr  : '0;
        e_wd   = (g == 0) ? i_wdata : (g == 1) ? d_wdata : '0;
        chk("mem_ren", mem_ren, e_ren);
        chk("mem_wen", mem_wen, e_wen);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wd);
        chk("i_stall", i_stall, ir && (g != 0));
        chk("d_stall", d_stall, dr && (g != 1));
        e_iv = 1'b0;
        e_dv = 1'b0;
        if (mem_data_valid && inflight.size() > 0) begin
            r = inflight[0];
            e_iv = (r.tag == 0);
            e_dv = (r.tag == 1);
            chk("rd_value", (r.tag == 0) ? i_rdata : d_rdata, memf(r.addr));
        end
        chk("i_data_valid", i_data_valid, e_iv);
        chk("d_data_valid", d_data_valid, e_dv);
        chk("i_rdata", i_rdata, (m_owner == 0) ? mem_rdata : '0);
        chk("d_rdata", d_rdata, (m_owner == 1) ? mem_rdata : '0);
        if (i_data_valid) cnt_iv++;
        if (d_data_valid) cnt_dv++;
        if (mem_wen && mem_addr == 16'h0040 && mem_wdata == 16'hBEEF) cnt_wr++;
        if (mem_ren && !prev_ren) gseq.push_back((i_ren && !i_stall) ? 0 : 1);
        prev_ren = mem_ren;

        i_acc = (g == 0) && ir;
        d_acc = (g == 1) && dr;
        if (mem_data_valid && inflight.size() > 0) inflight.delete(0);
        if (e_ren) begin
            r.tag  = g;
            r.addr = e_addr;
            inflight.push_back(r);
        end
        nm = ph;
        case (ph)
            FREE: if (ir || dr) begin
                if (ir && dr) w = RR ? ((m_last == 0) ? 1 : 0) : 0;
                else          w = ir ? 0 : 1;
                nm = (w == 0) ? OWN_I : OWN_D;
                m_owner = w;
                m_last  = w;
            end
            OWN_I: if (!ir) nm = (inflight.size() != 0) ? FLUSH : FREE;
            OWN_D: if (!dr) nm = (inflight.size() != 0) ? FLUSH : FREE;
            FLUSH: if (inflight.size() == 0) nm = FREE;
            default: ;
        endcase
        @(posedge clk);
        ph = nm;
        if (i_acc) accept(0);
        if (d_acc) accept(1);
        @(negedge clk);
    endtask

    task automatic run_until_quiet(input string tag, input int max_cyc);
        bit done;
        done = 1'b0;
        for (int n = 0; n < max_cyc && !done; n++) begin
            drive_clients();
            cycle();
            done = (ph == FREE) && (inflight.size() == 0) && (c_rem[0] == 0) && (c_rem[1] == 0)
                   && !c_auto[0] && !c_auto[1];
        end
        chk(tag, done, 1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        drive_clients();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int gk;
        vectors = 0;
        miscompares = 0;
        for (int c = 0; c < 2; c++) begin
            c_rem[c] = 0; c_idle[c] = 0; c_wr[c] = 1'b0; c_auto[c] = 1'b0;
            c_addr[c] = '0; c_wd[c] = '0;
        end
        fix_len = 0; fix_idle = 0; allow_wr = 1'b0;
        ph = FREE; m_owner = 0; m_last = 1; prev_ren = 1'b0;

        rst = 1'b1;
        drive_clients();
        cycle();
        cycle();
        rst = 1'b0;

        // icache-only burst of 8 reads
        c_rem[0] = 8; c_addr[0] = 16'h0000;
        cnt_iv = 0; cnt_dv = 0;
        run_until_quiet("t1_quiet", 40);
        chk("t1_i_valid_count", cnt_iv, 8);
        chk("t1_d_valid_count", cnt_dv, 0);

        // simultaneous requests
        c_rem[0] = 4; c_addr[0] = 16'h0100;
        c_rem[1] = 4; c_addr[1] = 16'h0200;
        cnt_iv = 0; cnt_dv = 0;
        run_until_quiet("t2_quiet", 60);
        chk("t2_i_valid_count", cnt_iv, 4);
        chk("t2_d_valid_count", cnt_dv, 4);

        // icache drops with reads in flight; dcache arrives during the drain
        c_rem[0] = 6; c_addr[0] = 16'h0300;
        cnt_iv = 0; cnt_dv = 0;
        repeat (7) begin
            drive_clients();
            cycle();
        end
        c_rem[1] = 2; c_addr[1] = 16'h0400;
        run_until_quiet("t3_quiet", 60);
        chk("t3_i_valid_count", cnt_iv, 6);
        chk("t3_d_valid_count", cnt_dv, 2);

        // single dcache write
        c_rem[1] = 1; c_wr[1] = 1'b1; c_addr[1] = 16'h0040; c_wd[1] = 16'hBEEF;
        cnt_wr = 0;
        run_until_quiet("t4_quiet", 20);
        chk("t4_write_pulses", cnt_wr, 1);
        c_wr[1] = 1'b0;

        // reset with three dcache reads outstanding, request still held
        c_rem[1] = 8; c_addr[1] = 16'h0500;
        repeat (4) begin
            drive_clients();
            cycle();
        end
        chk("t5_inflight_before_reset", pv[2:0], 3'b111);
        pulse_reset();
        c_rem[1] = 2; c_addr[1] = 16'h0600;
        cnt_iv = 0; cnt_dv = 0;
        run_until_quiet("t5_quiet", 40);
        chk("t5_d_valid_count", cnt_dv, 2);
        chk("t5_i_valid_count", cnt_iv, 0);

        // both clients requesting continuously with 2-read bursts
        pulse_reset();
        gseq.delete();
        fix_len = 2; fix_idle = 1; allow_wr = 1'b0;
        c_rem[0] = 0; c_rem[1] = 0; c_idle[0] = 0; c_idle[1] = 0;
        c_auto[0] = 1'b1; c_auto[1] = 1'b1;
        repeat (60) begin
            drive_clients();
            cycle();
        end
        c_auto[0] = 1'b0; c_auto[1] = 1'b0;
        run_until_quiet("t6_quiet", 80);
        chk("t6_grant_count", gseq.size() >= 4, 1);
        for (int k = 0; k < 4; k++) begin
            gk = (k < gseq.size()) ? gseq[k] : -1;
            chk($sformatf("t6_grant%0d", k), gk, RR ? (k % 2) : 0);
        end

        // random traffic including dcache writes
        fix_len = 0; fix_idle = 0; allow_wr = 1'b1;
        c_auto[0] = 1'b1; c_auto[1] = 1'b1;
        repeat (2000) begin
            drive_clients();
            cycle();
        end
        c_auto[0] = 1'b0; c_auto[1] = 1'b0;
        run_until_quiet("rand_quiet", 100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-client arbiter between the instruction cache and data cache miss ports and the shared multicycle memory (memory4c: pipelined, fixed read latency, data_valid strobe).
- Replaces the combinational priority muxing in the CPU top level.
- Holds a grant for a whole cache-fill burst and tracks in-flight reads, so responses always route to the client that issued them.
- Blocks the losing client with an explicit stall.

Parameters:
DATA_W, 16, data width of memory and client ports
ADDR_W, 16, address width
MEM_LAT, 4, cycles from mem_ren to the matching mem_data_valid
CNT_W, 3, outstanding-read counter width; must hold MEM_LAT+1

Ports:
clk  input  1  clock
rst  input  1  async reset, active-high
i_ren  input  1  icache read request
i_wen  input  1  icache write request (normally tied 0)
i_addr  input  ADDR_W  icache address
i_wdata  input  DATA_W  icache write data
i_rdata  output  DATA_W  read data to icache
i_data_valid  output  1  read data valid to icache
i_stall  output  1  icache requesting but not granted
d_ren, d_wen, d_addr, d_wdata, d_rdata, d_data_valid, d_stall  same as i_*, for dcache
mem_addr  output  ADDR_W  to memory
mem_wdata  output  DATA_W  to memory
mem_ren  output  1  to memory
mem_wen  output  1  to memory
mem_rdata  input  DATA_W  from memory
mem_data_valid  input  1  from memory

Behaviour:
- Request definition: x_req = x_ren | x_wen.
- Registered state: state {IDLE, GNT_I, GNT_D, DRAIN}; owner (0=I, 1=D); last (last granted client); outst[CNT_W-1:0].
- Reset values: state=IDLE, owner=0, last=1, outst=0.
- Reset output values: all outputs 0.
- IDLE:
  - If any request is present, grant it; the new state takes effect at the next clock edge.
  - No memory command is issued from IDLE. One cycle of arbitration latency applies.
  - Both requesting: priority rule below.
- GNT_x:
  - mem_addr, mem_wdata, mem_ren and mem_wen pass through combinationally from client x.
  - The other client's commands are masked to 0.
  - Stay in GNT_x while x_req=1.
  - On x_req=0: go to DRAIN if outst≠0 (after this cycle's update), else go to IDLE.
- DRAIN:
  - No commands are issued.
  - Wait until outst==0, then go to IDLE.
  - A new request from the owner during DRAIN is stalled until the next arbitration.
- Outstanding counter:
  - Increments on every cycle with mem_ren=1.
  - Decrements on mem_data_valid.
  - Unchanged when both occur in the same cycle.
  - mem_data_valid with outst==0 is ignored. No underflow; assertion in simulation.
- Response routing:
  - mem_data_valid goes to owner_data_valid; mem_rdata goes to owner_rdata.
  - The non-owner's rdata and data_valid are both 0. No tri-state drive.
  - owner stays constant through DRAIN, so late reads reach the issuing client.
- Writes:
  - Single-cycle, fire-and-forget.
  - Not counted in outst.
- Stall outputs:
  - x_stall = x_req & ~(state==GNT_x).
  - x_stall is 1 in IDLE when x_req=1.
  - The client must hold its request stable while stalled.
- Priority, default build: icache always wins over dcache in IDLE.
- Starvation: a client holding its request indefinitely starves the other. Caches bound this by burst length.
- Reset mid-burst: state returns to IDLE and outst clears immediately. Memory shares rst, so in-flight data is discarded.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: on simultaneous requests in IDLE, the client ≠ last wins; last updates on each grant.
- Undefined: fixed icache priority; last is still maintained but unused.

Test Plan:
1. icache only: i_ren=1 for 8 cycles, addr 0x0000..0x000E, memory returns addr-based data.
   - Grant arrives 1 cycle after request.
   - 8 i_data_valid pulses, each MEM_LAT cycles after its issue.
   - d_data_valid stays 0. State returns to IDLE once outst reaches 0.
2. Simultaneous i_ren and d_ren at cycle 0, fixed priority.
   - i granted; d_stall=1 throughout GNT_I and DRAIN.
   - d granted the cycle after IDLE is re-entered; no dcache memory command appears while owner=I.
3. icache drops its request with 4 reads in flight.
   - State goes to DRAIN; all 4 responses go to i_rdata.
   - A dcache request made during DRAIN sees d_stall=1 until outst=0.
4. dcache write: d_wen=1, d_addr=0x0040, d_wdata=0xBEEF for 1 cycle.
   - mem_wen=1 with the same addr and data while in GNT_D.
   - outst stays 0; state goes directly to IDLE after the request drops.
5. Reset asserted async while outst=3 in GNT_D.
   - All outputs go to 0 immediately.
   - After release: state=IDLE, outst=0, first grant works normally.
6. With ARB_ROUND_ROBIN_EN, both clients requesting continuously with bursts of 2 reads.
   - Grants alternate I, D, I, D.
   - Without the macro, I is re-granted whenever it requests.
